// File: rtl/subword_mem_ctrl.sv
// Initiator-side controller for a word-addressed memory: byte/half/word loads and stores,
// big-endian lanes, read-modify-write for sub-word stores, sign/zero-extended load data.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for req; latches the request on accept
// S_READ  | memory word captured; loads finish here, sub-word stores merge next
// S_WRITE | single mem_we cycle with the merged or full word
// S_DONE  | done pulse, err valid; req ignored here
module subword_mem_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_a,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_wr;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_word;
   logic        r_err;
   logic [31:0] r_rdata;

   logic        w_misalign;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   assign w_misalign = (size == 2'b11)
                     | ((size == 2'b01) & addr[0])
                     | ((size == 2'b10) & (addr[1:0] != 2'b00));

   // Lane extraction reads mem_rd directly so the load result lands on the READ edge.
   always_comb begin
      w_byte = 8'h00;
      case (r_addr[1:0])
         2'd0: w_byte = mem_rd[31:24];
         2'd1: w_byte = mem_rd[23:16];
         2'd2: w_byte = mem_rd[15:8];
         2'd3: w_byte = mem_rd[7:0];
         default: w_byte = 8'h00;
      endcase
      w_half = r_addr[1] ? mem_rd[15:0] : mem_rd[31:16];
      case (r_size)
         2'b00:   w_load = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = mem_rd;
      endcase
   end

   always_comb begin
      w_merge = r_word;
      case (r_size)
         2'b00: begin
            case (r_addr[1:0])
               2'd0: w_merge[31:24] = r_wdata[7:0];
               2'd1: w_merge[23:16] = r_wdata[7:0];
               2'd2: w_merge[15:8]  = r_wdata[7:0];
               2'd3: w_merge[7:0]   = r_wdata[7:0];
               default: w_merge = r_word;
            endcase
         end
         2'b01: begin
            if (r_addr[1]) w_merge[15:0]  = r_wdata[15:0];
            else           w_merge[31:16] = r_wdata[15:0];
         end
         default: w_merge = r_wdata;
      endcase
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign mem_we = (r_state == S_WRITE);
   assign err    = r_err;
   assign rdata  = r_rdata;
   assign mem_a  = ((r_state == S_READ) || (r_state == S_WRITE)) ? {r_addr[31:2], 2'b00} : 32'h0;
   assign mem_wd = (r_state == S_WRITE) ? w_merge : 32'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_wr    <= 1'b0;
         r_size  <= 2'b00;
         r_uns   <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_word  <= 32'h0;
         r_err   <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_wr    <= wr;
                  r_size  <= size;
                  r_uns   <= uns;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_err   <= w_misalign;
                  if (w_misalign)
                     r_state <= S_DONE;
                  else if (wr && (size == 2'b10))
                     r_state <= S_WRITE;
                  else
                     r_state <= S_READ;
               end
            end
            S_READ: begin
               r_word <= mem_rd;
               if (r_wr) begin
                  r_state <= S_WRITE;
               end else begin
                  r_rdata <= w_load;
                  r_state <= S_DONE;
               end
            end
            S_WRITE: r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Bench for subword_mem_ctrl: byte-level big-endian reference memory, scoreboard queues for
// completions and memory writes, checked on the falling clock edge.
module tb_subword_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, wr, uns;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        busy, done, err, mem_we;
   logic [31:0] rdata, mem_a, mem_wd, mem_rd;

   always #5 clk = ~clk;

   subword_mem_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .wr     (wr),
      .size   (size),
      .uns    (uns),
      .addr   (addr),
      .wdata  (wdata),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .rdata  (rdata),
      .mem_a  (mem_a),
      .mem_we (mem_we),
      .mem_wd (mem_wd),
      .mem_rd (mem_rd)
   );

   logic [31:0] mem [0:63];
   assign mem_rd = mem[mem_a[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

   logic [7:0] rb [0:255];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
      logic        st;
   } exp_t;
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   exp_t sq [$];
   wr_t  wq [$];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_done = -1;
   bit          spacing_on = 1'b0;
   logic [31:0] exp_rdata = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] rword(input logic [7:0] o);
      logic [7:0] b;
      b = o & 8'hFC;
      return {rb[b], rb[b + 8'd1], rb[b + 8'd2], rb[b + 8'd3]};
   endfunction

   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit keep, input bit abort);
      exp_t        e;
      wr_t         x;
      logic        mis;
      logic [7:0]  o;
      logic [15:0] h;
      int          t;
      t = 0;
      @(negedge clk);
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (busy) chk("idle_timeout", 32'(busy), 32'd0);
      mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      o = a[7:0];
      if (!mis && !w) begin
         case (sz)
            2'b00: exp_rdata = u ? {24'h0, rb[o]} : {{24{rb[o][7]}}, rb[o]};
            2'b01: begin
               h = {rb[o], rb[o + 8'd1]};
               exp_rdata = u ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: exp_rdata = rword(o);
         endcase
      end
      if (!mis && w && !abort) begin
         case (sz)
            2'b00: rb[o] = d[7:0];
            2'b01: begin
               rb[o]        = d[15:8];
               rb[o + 8'd1] = d[7:0];
            end
            default: begin
               rb[o]        = d[31:24];
               rb[o + 8'd1] = d[23:16];
               rb[o + 8'd2] = d[15:8];
               rb[o + 8'd3] = d[7:0];
            end
         endcase
         x.a = {24'h0, o & 8'hFC};
         x.d = rword(o);
         wq.push_back(x);
      end
      e.rdata = exp_rdata;
      e.err   = mis;
      e.st    = w & ~mis;
      e.lat   = mis ? 1 : ((w && sz != 2'b10) ? 3 : 2);
      wr = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1;
      @(posedge clk);
      #1;
      e.acc = cyc;
      if (!abort) sq.push_back(e);
      if (!keep) req = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (mem_we) begin
            if (wq.size() == 0) chk("spurious_we", 32'(mem_we), 32'd0);
            else begin
               wr_t x;
               x = wq.pop_front();
               chk("we_addr", mem_a, x.a);
               chk("we_data", mem_wd, x.d);
            end
         end
         if (!busy) begin
            chk("idle_mem_a", mem_a, 32'h0);
            chk("idle_mem_wd", mem_wd, 32'h0);
         end
         if (done) begin
            if (sq.size() == 0) chk("spurious_done", 32'(done), 32'd0);
            else begin
               exp_t e;
               e = sq.pop_front();
               chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
               chk("err", 32'(err), 32'(e.err));
               chk("rdata", rdata, e.rdata);
               if (e.st) chk("we_pending", 32'(wq.size()), 32'd0);
            end
            if (spacing_on && last_done >= 0) chk("done_spacing", 32'(cyc - last_done), 32'd3);
            last_done = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      for (int i = 0; i < 256; i++) rb[i] = 8'h0;
      mem[16] = 32'h11223344;
      mem[17] = 32'h55667788;
      mem[18] = 32'h99AABBCC;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] v;
         v = mem[16 + i];
         rb[64 + 4*i]     = v[31:24];
         rb[64 + 4*i + 1] = v[23:16];
         rb[64 + 4*i + 2] = v[15:8];
         rb[64 + 4*i + 3] = v[7:0];
      end
      req = 0; wr = 0; size = 0; uns = 0; addr = 0; wdata = 0;
      reset = 1'b0;
      #12;
      chk("rst_busy",   32'(busy),   32'd0);
      chk("rst_done",   32'(done),   32'd0);
      chk("rst_err",    32'(err),    32'd0);
      chk("rst_we",     32'(mem_we), 32'd0);
      chk("rst_mem_a",  mem_a,  32'h0);
      chk("rst_mem_wd", mem_wd, 32'h0);
      chk("rst_rdata",  rdata,  32'h0);
      @(negedge clk);
      reset = 1'b1;

      issue(0, 2'b10, 0, 32'h40, 32'h0, 0, 0);
      issue(1, 2'b00, 0, 32'h41, 32'h123456AB, 0, 0);
      issue(0, 2'b00, 0, 32'h41, 32'h0, 0, 0);
      issue(0, 2'b00, 1, 32'h41, 32'h0, 0, 0);
      issue(1, 2'b01, 0, 32'h42, 32'hCAFEBEEF, 0, 0);
      issue(0, 2'b01, 0, 32'h42, 32'h0, 0, 0);
      issue(0, 2'b10, 0, 32'h42, 32'h0, 0, 0);
      issue(0, 2'b11, 0, 32'h40, 32'h0, 0, 0);
      issue(0, 2'b01, 0, 32'h43, 32'h0, 0, 0);
      issue(1, 2'b10, 0, 32'h41, 32'hDEADDEAD, 0, 0);
      issue(1, 2'b00, 0, 32'h47, 32'h0000005A, 0, 0);
      issue(1, 2'b00, 0, 32'h44, 32'h000000C3, 0, 0);
      issue(0, 2'b01, 1, 32'h40, 32'h0, 0, 0);
      issue(1, 2'b10, 0, 32'h44, 32'h0BADF00D, 0, 0);
      issue(0, 2'b00, 0, 32'h47, 32'h0, 0, 0);

      // req pulses while busy must not start a second transaction
      issue(0, 2'b10, 0, 32'h44, 32'h0, 0, 0);
      @(negedge clk);
      req = 1; wr = 1; size = 2'b10; addr = 32'h48; wdata = 32'hFFFFFFFF;
      @(negedge clk);
      req = 0;

      // reset during READ of a sub-word store
      issue(1, 2'b00, 0, 32'h40, 32'h000000EE, 0, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_busy",  32'(busy),   32'd0);
      chk("abort_we",    32'(mem_we), 32'd0);
      chk("abort_mem_a", mem_a, 32'h0);
      chk("abort_rdata", rdata, 32'h0);
      exp_rdata = 32'h0;
      sq.delete();
      wq.delete();
      @(negedge clk);
      reset = 1'b1;
      chk("abort_mem", mem[16], rword(8'h40));
      issue(0, 2'b10, 0, 32'h40, 32'h0, 0, 0);

      // back-to-back with req held high
      t = 0;
      while ((busy || sq.size() > 0) && t < 50) begin
         @(negedge clk);
         t++;
      end
      spacing_on = 1'b1;
      last_done = -1;
      issue(0, 2'b10, 0, 32'h40, 32'h0, 1, 0);
      issue(0, 2'b10, 0, 32'h44, 32'h0, 1, 0);
      issue(0, 2'b10, 0, 32'h48, 32'h0, 0, 0);

      t = 0;
      while ((sq.size() > 0 || busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 32'(sq.size()), 32'd0);
      spacing_on = 1'b0;
      chk("mem_40", mem[16], rword(8'h40));
      chk("mem_44", mem[17], rword(8'h44));
      chk("mem_48", mem[18], rword(8'h48));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/subword_mem_ctrl.md
# subword_mem_ctrl

Initiator-side controller for the multicycle datapath's unified word-addressed memory, which has a combinational read and a write on the clock edge. It accepts byte, halfword and word load/store requests from the core over a req/done handshake. It issues word-aligned accesses to the memory, performing read-modify-write for sub-word stores, and returns extracted, sign- or zero-extended load data. Byte order is big-endian: byte offset 0 is bits [31:24].

## Interface
Parameters:
- none

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req, input, 1: core request; sampled only in IDLE.
- wr, input, 1: 1 = store, 0 = load.
- size, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as a misaligned access).
- uns, input, 1: loads only; 1 = zero-extend, 0 = sign-extend.
- addr, input, 32: byte address.
- wdata, input, 32: store data, right-justified (byte in [7:0], half in [15:0]).
- busy, output, 1: high in every state other than IDLE.
- done, output, 1: one-cycle completion pulse.
- err, output, 1: valid with done; 1 = misaligned or reserved size.
- rdata, output, 32: load result; held from done until the next load's done.
- mem_a, output, 32: word address {addr_q[31:2], 2'b00}.
- mem_we, output, 1: memory write enable.
- mem_wd, output, 32: memory write data.
- mem_rd, input, 32: memory read data, combinational from mem_a.

## Operation
- States: IDLE, READ, WRITE, DONE.
- Accept condition: in IDLE with req=1, latch wr, size, uns, addr and wdata into *_q registers.
- Next state from IDLE on accept:
  - err if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]≠0. Go to DONE with err_q=1.
  - word store: go to WRITE.
  - otherwise (loads and sub-word stores): go to READ.
- READ: register mem_rd into word_q.
  - For a load, compute the extracted, extended result into rdata at this edge, then go to DONE.
  - For a store, go to WRITE.
- WRITE: mem_we=1 for exactly this one cycle. mem_wd is:
  - word: wdata_q.
  - half: word_q with lane addr_q[1] replaced by wdata_q[15:0]. addr_q[1]=0 selects [31:16].
  - byte: word_q with lane addr_q[1:0] replaced by wdata_q[7:0]. Offset 0 selects [31:24], offset 3 selects [7:0].
  - Next state is DONE.
- DONE: done=1 and err=err_q, then return to IDLE. A req seen in DONE is ignored; it is accepted the following cycle if still high.
- Load extraction follows the same lane mapping as stores. Extension to 32 bits uses uns_q.
- In IDLE and DONE, mem_a is 0. In READ and WRITE, mem_a holds the latched word address.
- mem_wd is 0 outside WRITE.
- mem_we, busy and done are decoded combinationally from the state register.
- err is cleared on the next accept.
- rdata is unchanged by stores and by erroring requests.

## Timing
- Reset values: state IDLE; busy, done, err, mem_we all 0; mem_a, mem_wd and rdata all 0; all *_q registers 0.
- Reset asserted at any time forces IDLE immediately and asynchronously. mem_we drops at once, so an in-flight WRITE is abandoned; software must reissue the store. Operation resumes on the first rising edge after reset deasserts.
- Latency counts edges from the accept edge to the done cycle:
  - load: 2 (IDLE→READ→DONE).
  - word store: 2 (IDLE→WRITE→DONE).
  - sub-word store: 3 (IDLE→READ→WRITE→DONE).
  - error: 1 (IDLE→DONE).
- Maximum throughput is one request per latency+1 cycles. With req held high, requests are spaced by the IDLE cycle.
- Exactly one mem_we cycle per store. Loads and errors never assert mem_we.

## Test plan
- Preload word 0x40 = 0x11223344; issue load, size=10, addr 0x40. Required: done 2 cycles after accept; rdata=0x11223344; err=0; mem_we never high.
- Store byte 0xAB at addr 0x41. Required: one mem_we cycle with mem_a=0x40 and mem_wd=0x11AB3344; done 3 cycles after accept. Then signed byte load at 0x41 gives 0xFFFFFFAB; the same load with uns=1 gives 0x000000AB.
- Store half 0xBEEF at addr 0x42. Required: mem_wd=0x11ABBEEF; a subsequent half load at 0x42 with uns=0 gives 0xFFFFBEEF.
- Word load at 0x42, and separately size=11. Required: err=1 with done 1 cycle after accept; no mem_we; memory unchanged; rdata keeps its previous value.
- Assert reset low during READ of a sub-word store. Required: busy, mem_we and mem_a go to 0 immediately; memory unchanged. After release, a word load at 0x40 completes normally.
- req held high across three back-to-back word loads at 0x40, 0x44 and 0x48. Required: three done pulses, each 3 cycles apart; req toggling while busy=1 has no effect.
